pipeline_stall_ctrl: RTL

Sequential pipeline control block that consumes the combinational stall requests produced by the hazard detection logic and drives the per-stage enable, flush and bubble controls of the 5-stage pipeline. It guarantees exactly one bubble per load-use hazard. It holds fetch across an unresolved branch or jump until the execute stage returns a resolution handshake, and it issues the PC redirect strobe. It sits between the hazard unit and the IF/ID and ID/EX pipeline registers, and also keeps a saturating stall-cycle counter and a sticky protocol-error flag.

---
 rtl/pipe_ctrl_pkg.sv | 23 ++
 rtl/pipeline_stall_ctrl_sat_counter.sv | 27 ++
 rtl/pipeline_stall_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall controller.
//   state_e      : controller FSM state encoding
//   stage_ctrl_t : per-cycle stage control bundle driven to the pipeline registers
//   WAIT_CNT_W   : width of the branch-wait cycle counter
package pipe_ctrl_pkg;

  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LD_HOLD = 2'd1,
    BR_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic en_f;
    logic en_d;
    logic flush_d;
    logic bubble_e;
    logic redirect;
  } stage_ctrl_t;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and async active-low reset.
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : synchronous clear to zero (wins over inc)
//   inc        : increment enable; holds at all-ones once saturated
//   count      : registered count value
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count register; stops at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall controller: turns hazard-unit stall requests into stage
// enables, flush/bubble controls and the PC redirect strobe.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   load_use_req                : load-use hazard request (one bubble per hazard)
//   branch_req                  : branch/jump in Decode, fetch must hold
//   resolve_valid/resolve_taken : execute-stage branch resolution handshake
//   en_f, en_d                  : fetch / IF-ID write enables (Mealy)
//   flush_d, bubble_e           : NOP insertion into IF-ID / ID-EX (Mealy)
//   redirect                    : PC takes branch target this cycle (Mealy)
//   stall_active                : high whenever en_f is low
//   stall_cycles                : saturating count of en_f=0 cycles
//   timeout_err, protocol_err   : sticky error flags, cleared only by reset
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use_req,
  input  logic             branch_req,
  input  logic             resolve_valid,
  input  logic             resolve_taken,
  output logic             en_f,
  output logic             en_d,
  output logic             flush_d,
  output logic             bubble_e,
  output logic             redirect,
  output logic             stall_active,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             timeout_err,
  output logic             protocol_err
);

  // wait_cnt value whose increment brings it to WAIT_MAX.
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_MAX - 1);

  state_e                  state, state_nxt_c;
  stage_ctrl_t             ctrl_c;
  logic                    wait_clr_c;
  logic                    wait_inc_c;
  logic                    timeout_set_c;
  logic                    protocol_set_c;
  logic [WAIT_CNT_W-1:0]   wait_cnt;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt_c;
    end
  end

  // Next-state and Mealy stage-control decode.
  always_comb begin
    ctrl_c      = '{en_f: 1'b1, en_d: 1'b1, default: 1'b0};
    state_nxt_c = state;
    wait_clr_c  = 1'b0;
    wait_inc_c  = 1'b0;
    case (state)
      RUN, LD_HOLD: begin
        if ((state == RUN) && load_use_req) begin
          ctrl_c.en_f     = 1'b0;
          ctrl_c.en_d     = 1'b0;
          ctrl_c.bubble_e = 1'b1;
          state_nxt_c     = LD_HOLD;
        end else if (branch_req && resolve_valid) begin
          ctrl_c.redirect = resolve_taken;
          state_nxt_c     = RUN;
        end else if (branch_req) begin
          ctrl_c.en_f    = 1'b0;
          ctrl_c.flush_d = 1'b1;
          wait_clr_c     = 1'b1;
          state_nxt_c    = BR_WAIT;
        end else if ((state == LD_HOLD) && load_use_req) begin
          // A request still held after its bubble is the same hazard: stay masked.
          state_nxt_c = LD_HOLD;
        end else begin
          state_nxt_c = RUN;
        end
      end
      BR_WAIT: begin
        if (resolve_valid) begin
          ctrl_c.redirect = resolve_taken;
          state_nxt_c     = RUN;
        end else begin
          ctrl_c.en_f    = 1'b0;
          ctrl_c.flush_d = 1'b1;
          wait_inc_c     = 1'b1;
        end
      end
      default: begin
        state_nxt_c = RUN;
      end
    endcase
  end

  assign en_f         = ctrl_c.en_f;
  assign en_d         = ctrl_c.en_d;
  assign flush_d      = ctrl_c.flush_d;
  assign bubble_e     = ctrl_c.bubble_e;
  assign redirect     = ctrl_c.redirect;
  assign stall_active = ~ctrl_c.en_f;

  // Timeout fires on the edge where wait_cnt reaches WAIT_MAX.
  assign timeout_set_c  = wait_inc_c && (wait_cnt >= WAIT_LAST);
  assign protocol_set_c = (state != BR_WAIT) && resolve_valid && !branch_req;

  // Sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err  <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      if (timeout_set_c) begin
        timeout_err <= 1'b1;
      end
      if (protocol_set_c) begin
        protocol_err <= 1'b1;
      end
    end
  end

  // Cycles spent waiting for branch resolution.
  sat_counter #(.W(WAIT_CNT_W)) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wait_clr_c),
    .inc   (wait_inc_c),
    .count (wait_cnt)
  );

  // Total fetch-stall cycles since reset.
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (~ctrl_c.en_f),
    .count (stall_cycles)
  );

endmodule
